// File: rtl/tlul_pkg.sv
// TL-UL bus types, opcodes and the response integrity generator shared by
// devices on the management peripherals crossbar.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;

  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [13:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  // Folds a 64-bit vector into a 7-bit check code.
  function automatic logic [6:0] fold7(input logic [63:0] v);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      r[i % 7] = r[i % 7] ^ v[i];
    end
    return r;
  endfunction

  // Response integrity: {header code, data code} carried on d_user.
  function automatic logic [13:0] gen_rsp_user(input logic [2:0]  op,
                                               input logic [1:0]  size,
                                               input logic        err,
                                               input logic [31:0] data);
    return {fold7({56'h0, op, size, err, 2'b00}), fold7({32'h0, data})};
  endfunction

endpackage

// File: rtl/vicuna_cluster_ctrl_pkg.sv
// Register map, per-core state encoding and STATUS layout for the vicuna
// cluster controller.
package vicuna_cluster_ctrl_pkg;

  localparam int MaxCores = 8;
  localparam int RegAw    = 8;

  localparam logic [RegAw-1:0] CtrlOff       = 8'h00;
  localparam logic [RegAw-1:0] StatusOff     = 8'h04;
  localparam logic [RegAw-1:0] BootAddrOff   = 8'h08;
  localparam logic [RegAw-1:0] IntrStateOff  = 8'h0C;
  localparam logic [RegAw-1:0] IntrEnableOff = 8'h10;
  localparam logic [RegAw-1:0] CyclesOff     = 8'h20;

  localparam int StatusRunLsb  = 0;
  localparam int StatusDoneLsb = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } core_state_e;

  // Offset of the cycle counter register for core i.
  function automatic logic [RegAw-1:0] cycles_off(input int i);
    return CyclesOff + RegAw'(4 * i);
  endfunction

endpackage

// File: rtl/vicuna_cluster_ctrl_core.sv
// Per-core launch FSM (IDLE/RUN/DONE) with run-cycle counter.
// Macro VICUNA_CLUSTER_CTRL_CYCLE_CNT_EN: when defined the saturating cycle
// counter is built; otherwise cycles_o is tied to zero.
// A CTRL write (run_i or stop_i) in the same cycle as done_i wins: the done
// is dropped and no event is raised.
module vicuna_cluster_ctrl_core
  import vicuna_cluster_ctrl_pkg::*;
#(
  parameter int CntW = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            run_i,
  input  logic            stop_i,
  input  logic            done_i,
  output core_state_e     state_o,
  output logic            core_rst_no,
  output logic            done_evt_o,
  output logic [CntW-1:0] cycles_o
);

  core_state_e state_q, state_d;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and completion event.
  always_comb begin
    state_d    = state_q;
    done_evt_o = 1'b0;
    unique case (state_q)
      IDLE: if (run_i) state_d = RUN;
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (!run_i && done_i) begin
          state_d    = DONE;
          done_evt_o = 1'b1;
        end
      end
      DONE: begin
        if (run_i)       state_d = RUN;
        else if (stop_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o     = state_q;
  assign core_rst_no = (state_q == RUN);

`ifdef VICUNA_CLUSTER_CTRL_CYCLE_CNT_EN
  logic [CntW-1:0] cnt_q;

  // Cleared on launch, counts every cycle spent in RUN, saturates at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q != RUN && run_i) begin
      cnt_q <= '0;
    end else if (state_q == RUN && cnt_q != '1) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign cycles_o = cnt_q;
`else
  assign cycles_o = '0;
`endif

endmodule

// File: rtl/vicuna_cluster_ctrl.sv
// TL-UL register device that launches vicuna cores and reports completion.
// Macro VICUNA_CLUSTER_CTRL_CYCLE_CNT_EN enables the per-core CYCLES counters;
// without it the CYCLES offsets still decode and read zero.
// Handshake: one transaction in flight. a_ready = !rsp_valid_q; a request is
// taken on a_valid && a_ready, its response is valid the following cycle and
// is held until d_ready.
module vicuna_cluster_ctrl
  import tlul_pkg::*;
  import vicuna_cluster_ctrl_pkg::*;
#(
  parameter int          NumCores        = 2,
  parameter logic [31:0] BootAddrDefault = 32'h0000_0000,
  parameter int          CntW            = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  tlul_pkg::tl_h2d_t   tl_i,
  output tlul_pkg::tl_d2h_t   tl_o,
  output logic [NumCores-1:0] core_rst_no,
  output logic [31:0]         core_boot_addr_o,
  input  logic [NumCores-1:0] core_done_i,
  output logic                irq_o
);

  logic                rsp_valid_q, rsp_err_q;
  logic [2:0]          rsp_op_q;
  logic [1:0]          rsp_size_q;
  logic [7:0]          rsp_source_q;
  logic [31:0]         rsp_data_q;
  logic [31:0]         boot_q;
  logic [NumCores-1:0] intr_state_q, intr_en_q;
  logic                irq_q;

  core_state_e         core_state [NumCores];
  logic [CntW-1:0]     cycles     [NumCores];
  logic [NumCores-1:0] running, done_st, done_evt;

  logic                a_ready, req, is_get, is_put, err;
  logic                hit_ctrl, hit_status, hit_boot, hit_intr_state, hit_intr_en;
  logic                hit_cycles, mapped, hit_ro;
  logic                wr, ctrl_wr;
  logic [RegAw-1:0]    offset;
  logic [31:0]         rdata;

  assign a_ready = !rsp_valid_q;
  assign req     = tl_i.a_valid && a_ready;
  assign offset  = tl_i.a_address[RegAw-1:0];
  assign is_get  = (tl_i.a_opcode == Get);
  assign is_put  = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);

  // Address decode and legality of the incoming request.
  always_comb begin
    hit_ctrl       = (offset == CtrlOff);
    hit_status     = (offset == StatusOff);
    hit_boot       = (offset == BootAddrOff);
    hit_intr_state = (offset == IntrStateOff);
    hit_intr_en    = (offset == IntrEnableOff);
    hit_cycles     = 1'b0;
    for (int i = 0; i < NumCores; i++) begin
      if (offset == cycles_off(i)) hit_cycles = 1'b1;
    end
    mapped = hit_ctrl | hit_status | hit_boot | hit_intr_state | hit_intr_en | hit_cycles;
    hit_ro = hit_status | hit_cycles;
    err    = !(is_get || is_put) || (tl_i.a_size != 2'd2) || !mapped ||
             (is_put && ((tl_i.a_mask != 4'hF) || hit_ro));
  end

  assign wr      = req && is_put && !err;
  assign ctrl_wr = wr && hit_ctrl;

  // One controller per core; CTRL bit i set launches, clear stops.
  for (genvar g = 0; g < NumCores; g++) begin : g_core
    vicuna_cluster_ctrl_core #(
      .CntW (CntW)
    ) u_core (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .run_i       (ctrl_wr && tl_i.a_data[g]),
      .stop_i      (ctrl_wr && !tl_i.a_data[g]),
      .done_i      (core_done_i[g]),
      .state_o     (core_state[g]),
      .core_rst_no (core_rst_no[g]),
      .done_evt_o  (done_evt[g]),
      .cycles_o    (cycles[g])
    );
    assign running[g] = (core_state[g] == RUN);
    assign done_st[g] = (core_state[g] == DONE);
  end

  // Read data mux, evaluated on the accepting cycle.
  always_comb begin
    rdata = '0;
    if (hit_ctrl) rdata[NumCores-1:0] = running;
    if (hit_status) begin
      rdata[StatusRunLsb +: NumCores]  = running;
      rdata[StatusDoneLsb +: NumCores] = done_st;
    end
    if (hit_boot)       rdata = {boot_q[31:2], 2'b00};
    if (hit_intr_state) rdata[NumCores-1:0] = intr_state_q;
    if (hit_intr_en)    rdata[NumCores-1:0] = intr_en_q;
    for (int i = 0; i < NumCores; i++) begin
      if (offset == cycles_off(i)) rdata = 32'(cycles[i]);
    end
  end

  // Software-visible registers; boot address only changes with all cores idle,
  // and a hardware interrupt set beats a same-cycle W1C.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      boot_q       <= BootAddrDefault;
      intr_state_q <= '0;
      intr_en_q    <= '0;
      irq_q        <= 1'b0;
    end else begin
      if (wr && hit_boot && (running == '0) && (done_st == '0)) begin
        boot_q <= {tl_i.a_data[31:2], 2'b00};
      end
      if (wr && hit_intr_en) intr_en_q <= tl_i.a_data[NumCores-1:0];
      if (wr && hit_intr_state) begin
        intr_state_q <= (intr_state_q & ~tl_i.a_data[NumCores-1:0]) | done_evt;
      end else begin
        intr_state_q <= intr_state_q | done_evt;
      end
      irq_q <= |(intr_state_q & intr_en_q);
    end
  end

  // Response register: captured on accept, released on d_ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_op_q     <= AccessAck;
      rsp_size_q   <= '0;
      rsp_source_q <= '0;
      rsp_data_q   <= '0;
    end else if (req) begin
      rsp_valid_q  <= 1'b1;
      rsp_err_q    <= err;
      rsp_op_q     <= is_get ? AccessAckData : AccessAck;
      rsp_size_q   <= tl_i.a_size;
      rsp_source_q <= tl_i.a_source;
      rsp_data_q   <= (is_get && !err) ? rdata : 32'h0;
    end else if (tl_i.d_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  // Drive the response channel.
  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = rsp_valid_q;
    tl_o.d_opcode = rsp_op_q;
    tl_o.d_size   = rsp_size_q;
    tl_o.d_source = rsp_source_q;
    tl_o.d_data   = rsp_data_q;
    tl_o.d_error  = rsp_err_q;
    tl_o.d_user   = gen_rsp_user(rsp_op_q, rsp_size_q, rsp_err_q, rsp_data_q);
    tl_o.a_ready  = a_ready;
  end

  assign core_boot_addr_o = boot_q;
  assign irq_o            = irq_q;

  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:RegAw]};

endmodule

// File: tb/tb_vicuna_cluster_ctrl.sv
// Scoreboard bench for vicuna_cluster_ctrl: directed scenarios followed by a
// randomized phase, checked against a register-level reference model.
module tb_vicuna_cluster_ctrl;
  import tlul_pkg::*;

  localparam int          NC       = 2;
  localparam logic [31:0] BOOT_DEF = 32'h8000_0000;
  localparam int          CW       = 8;
  localparam int          SAT      = (1 << CW) - 1;
`ifdef VICUNA_CLUSTER_CTRL_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid = 1'b0;
  logic [2:0]  a_opcode = '0;
  logic [1:0]  a_size = '0;
  logic [7:0]  a_source = '0;
  logic [31:0] a_address = '0;
  logic [3:0]  a_mask = '0;
  logic [31:0] a_data = '0;
  logic        d_ready = 1'b1;
  logic        hold_low = 1'b0;

  tl_h2d_t           tl_i;
  tl_d2h_t           tl_o;
  logic [NC-1:0]     core_rst_n;
  logic [NC-1:0]     core_done = '0;
  logic [31:0]       boot;
  logic              irq;

  assign tl_i = {a_valid, a_opcode, 3'b000, a_size, a_source, a_address, a_mask, a_data, d_ready};

  vicuna_cluster_ctrl #(
    .NumCores        (NC),
    .BootAddrDefault (BOOT_DEF),
    .CntW            (CW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .tl_i             (tl_i),
    .tl_o             (tl_o),
    .core_rst_no      (core_rst_n),
    .core_boot_addr_o (boot),
    .core_done_i      (core_done),
    .irq_o            (irq)
  );

  int cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    d_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int            st      [NC];
  int            start_c [NC];
  int            frozen  [NC];
  logic [31:0]   m_boot;
  logic [NC-1:0] m_intr, m_en;

  int errors = 0;
  int checks = 0;
  logic [45:0] exp_q[$];

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  function automatic logic [31:0] m_cycles(input int i, input int now);
    if (!CNT_EN) return 32'h0;
    if (st[i] == S_RUN) return 32'(sat(now - start_c[i] - 1));
    return 32'(frozen[i]);
  endfunction

  function automatic logic [NC-1:0] m_running();
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++) r[i] = (st[i] == S_RUN);
    return r;
  endfunction

  function automatic logic [NC-1:0] m_done_st();
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++) r[i] = (st[i] == S_DONE);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      st[i] = S_IDLE; start_c[i] = 0; frozen[i] = 0;
    end
    m_boot = BOOT_DEF & 32'hFFFF_FFFC;
    m_intr = '0;
    m_en   = '0;
  endtask

  task automatic apply_done(input logic [NC-1:0] dm, input int now);
    for (int i = 0; i < NC; i++) begin
      if (dm[i] && st[i] == S_RUN) begin
        st[i]     = S_DONE;
        frozen[i] = sat(now - start_c[i]);
        m_intr[i] = 1'b1;
      end
    end
  endtask

  task automatic model_access(input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] mask,
                              input logic [1:0] size, input logic [NC-1:0] dm,
                              input int now, output logic err, output logic [31:0] rd);
    logic [7:0] off;
    int  cidx;
    bit  is_get, is_put, mapped, ro, ctrl_wr;
    off    = addr[7:0];
    is_get = (op == Get);
    is_put = (op == PutFullData) || (op == PutPartialData);
    cidx   = -1;
    if (int'(off) >= 32 && int'(off) < 32 + 4 * NC && off[1:0] == 2'b00) cidx = (int'(off) - 32) / 4;
    mapped = (off == 8'h00) || (off == 8'h04) || (off == 8'h08) || (off == 8'h0C) ||
             (off == 8'h10) || (cidx >= 0);
    ro     = (off == 8'h04) || (cidx >= 0);
    err    = !(is_get || is_put) || (size != 2'd2) || !mapped ||
             (is_put && (mask != 4'hF || ro));
    rd      = 32'h0;
    ctrl_wr = 1'b0;
    if (!err && is_get) begin
      case (off)
        8'h00:   rd = 32'(m_running());
        8'h04:   rd = 32'(m_running()) | (32'(m_done_st()) << 8);
        8'h08:   rd = m_boot;
        8'h0C:   rd = 32'(m_intr);
        8'h10:   rd = 32'(m_en);
        default: rd = m_cycles(cidx, now);
      endcase
    end
    if (!err && is_put) begin
      case (off)
        8'h00: begin
          ctrl_wr = 1'b1;
          for (int i = 0; i < NC; i++) begin
            if (data[i]) begin
              if (st[i] != S_RUN) begin st[i] = S_RUN; start_c[i] = now; end
            end else begin
              if (st[i] == S_RUN) frozen[i] = sat(now - start_c[i]);
              st[i] = S_IDLE;
            end
          end
        end
        8'h08:   if (m_running() == '0 && m_done_st() == '0) m_boot = data & 32'hFFFF_FFFC;
        8'h0C:   m_intr = m_intr & ~data[NC-1:0];
        8'h10:   m_en = data[NC-1:0];
        default: ;
      endcase
    end
    if (!ctrl_wr) apply_done(dm, now);
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares each response as it is handed over.
  logic [45:0] mon_act, mon_exp;
  always @(negedge clk) begin
    if (rst_n && tl_o.d_valid && d_ready) begin
      checks++;
      mon_act = {tl_o.d_size, tl_o.d_source, tl_o.d_opcode, tl_o.d_error, tl_o.d_data};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tl_rsp unexpected: got 0x%012h with nothing expected", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL tl_rsp {size,src,op,err,data}: got 0x%012h expected 0x%012h", mon_act, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks (enter/leave 1 time unit after posedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tl_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [1:0] size, input logic [NC-1:0] dm);
    logic        err;
    logic [31:0] rd;
    bit          ok;
    ok        = 1'b0;
    a_valid   = 1'b1;
    a_opcode  = op;
    a_address = addr;
    a_data    = data;
    a_mask    = mask;
    a_size    = size;
    a_source  = 8'($urandom_range(0, 255));
    core_done = dm;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tl_o.a_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      model_access(op, addr, data, mask, size, dm, cyc, err, rd);
      exp_q.push_back({size, a_source, (op == Get) ? AccessAckData : AccessAck, err, rd});
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL tl_accept timeout: got a_ready=0 for 200 cycles expected acceptance");
    end
    a_valid   = 1'b0;
    core_done = '0;
    @(negedge clk);
    chk("core_rst_no", 32'(core_rst_n), 32'(m_running()));
    chk("core_boot_addr", boot, m_boot);
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [31:0] addr);
    tl_req(Get, addr, 32'h0, 4'hF, 2'd2, '0);
  endtask

  task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data);
    tl_req(PutFullData, addr, data, 4'hF, 2'd2, '0);
  endtask

  task automatic pulse_done(input logic [NC-1:0] dm);
    core_done = dm;
    @(posedge clk);
    apply_done(dm, cyc);
    #1;
    core_done = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: got %0d responses pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_irq();
    idle(2);
    @(negedge clk);
    chk("irq_o", 32'(irq), 32'(|(m_intr & m_en)));
    chk("core_rst_no_idle", 32'(core_rst_n), 32'(m_running()));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    a_valid   = 1'b0;
    core_done = '0;
    exp_q.delete();
    model_reset();
    #2;
    chk("rst core_rst_no", 32'(core_rst_n), 32'h0);
    chk("rst irq_o", 32'(irq), 32'h0);
    chk("rst d_valid", 32'(tl_o.d_valid), 32'h0);
    chk("rst a_ready", 32'(tl_o.a_ready), 32'h1);
    chk("rst boot_addr", boot, BOOT_DEF);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rand_addrs[10] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10,
                                  32'h20, 32'h24, 32'h28, 32'h44, 32'h14};

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Reset readback.
    rd_reg(32'h00); rd_reg(32'h04); rd_reg(32'h0C);
    rd_reg(32'h08); rd_reg(32'h10); rd_reg(32'h20);

    // Boot address write, launch core 0, later boot write ignored.
    wr_reg(32'h08, 32'h0001_0003);
    rd_reg(32'h08);
    wr_reg(32'h00, 32'h1);
    wr_reg(32'h08, 32'hDEAD_BEEF);
    rd_reg(32'h08);

    // Run ~100 cycles, done pulse with interrupt enabled.
    wr_reg(32'h10, 32'h1);
    idle(100);
    pulse_done(2'b01);
    chk_irq();
    rd_reg(32'h04);
    rd_reg(32'h20);
    idle(5);
    rd_reg(32'h20);
    wr_reg(32'h0C, 32'h1);
    chk_irq();

    // CTRL write coincident with done: write wins.
    wr_reg(32'h00, 32'h1);
    idle(10);
    drain();
    tl_req(PutFullData, 32'h00, 32'h1, 4'hF, 2'd2, 2'b01);
    rd_reg(32'h04);
    rd_reg(32'h0C);
    chk_irq();
    wr_reg(32'h00, 32'h0);
    rd_reg(32'h00);

    // Error responses, no side effects.
    rd_reg(32'h44);
    tl_req(PutPartialData, 32'h00, 32'h1, 4'h3, 2'd2, '0);
    wr_reg(32'h04, 32'hFFFF_FFFF);
    tl_req(Get, 32'h00, 32'h0, 4'hF, 2'd1, '0);
    tl_req(3'h3, 32'h00, 32'h1, 4'hF, 2'd2, '0);
    tl_req(PutPartialData, 32'h10, 32'h3, 4'hF, 2'd2, '0);
    rd_reg(32'h00);
    rd_reg(32'h10);

    // Backpressure: a_ready stays low while the response is held.
    drain();
    hold_low = 1'b1;
    rd_reg(32'h08);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("a_ready backpressure", 32'(tl_o.a_ready), 32'h0);
      chk("d_valid held", 32'(tl_o.d_valid), 32'h1);
    end
    @(posedge clk);
    #1;
    hold_low = 1'b0;
    rd_reg(32'h04);

    // Hardware set beats W1C on the same bit.
    wr_reg(32'h00, 32'h1);
    idle(4);
    drain();
    tl_req(PutFullData, 32'h0C, 32'h1, 4'hF, 2'd2, 2'b01);
    chk_irq();
    rd_reg(32'h0C);
    wr_reg(32'h0C, 32'h3);
    chk_irq();

    // Counter saturation on core 1.
    wr_reg(32'h00, 32'h2);
    idle(300);
    rd_reg(32'h24);
    pulse_done(2'b10);
    rd_reg(32'h24);
    rd_reg(32'h04);
    wr_reg(32'h00, 32'h0);

    // Randomized phase.
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: rd_reg(rand_addrs[$urandom_range(0, 9)]);
        3:       wr_reg(32'h00, $urandom);
        4:       wr_reg(32'h10, $urandom);
        5:       wr_reg(32'h0C, $urandom);
        6:       wr_reg(32'h08, $urandom);
        7:       pulse_done(NC'($urandom_range(1, 3)));
        8:       tl_req(3'($urandom_range(0, 7)), rand_addrs[$urandom_range(0, 9)], $urandom,
                        4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), '0);
        default: idle($urandom_range(1, 20));
      endcase
      chk_irq();
    end
    rd_reg(32'h04);
    rd_reg(32'h20);
    rd_reg(32'h24);

    // Reset with a core running and a response pending.
    drain();
    wr_reg(32'h00, 32'h3);
    hold_low = 1'b1;
    rd_reg(32'h00);
    do_reset();
    hold_low = 1'b0;
    rd_reg(32'h00);
    rd_reg(32'h0C);
    rd_reg(32'h20);

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
